// File: rtl/bip_pkg.sv
// Shared definitions for the BIP I control unit: opcodes, accumulator source
// encodings, FSM states and small opcode classification helpers.
package bip_pkg;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    localparam logic [1:0] SELA_MEM = 2'b00;
    localparam logic [1:0] SELA_IMM = 2'b01;
    localparam logic [1:0] SELA_ALU = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_MEMRD  = 3'd3,
        ST_EXEC   = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    // Only the low eight opcodes are defined; everything above is a NOP.
    function automatic logic is_legal(input logic [4:0] opc);
        return opc[4:3] == 2'b00;
    endfunction

    function automatic logic needs_memrd(input logic [4:0] opc);
        return (opc == OP_LD) || (opc == OP_ADD) || (opc == OP_SUB);
    endfunction

    function automatic logic writes_acc(input logic [4:0] opc);
        return is_legal(opc) && (opc != OP_HLT) && (opc != OP_STO);
    endfunction

endpackage

// File: rtl/bip_if.sv
// Instruction fetch, datapath control and data-memory strobe bundle of the
// BIP I control unit. master = control unit, slave = memories/datapath.
interface bip_if #(
    parameter int NBITS_O = 11,
    parameter int NBITS_E = 5,
    parameter int NBITS_C = 16
);
    logic                       i_start;
    logic [NBITS_O-1:0]         o_PcAddr;
    logic [NBITS_E+NBITS_O-1:0] i_Instruction;
    logic [1:0]                 o_SelA;
    logic                       o_SelB;
    logic                       o_Op;
    logic                       o_WrAcc;
    logic [NBITS_O-1:0]         o_Operand;
    logic                       o_RdRam;
    logic                       o_WrRam;
    logic                       o_Halt;
    logic                       o_Illegal;
    logic [NBITS_C-1:0]         o_InstrCount;

    modport master (
        input  i_start, i_Instruction,
        output o_PcAddr, o_SelA, o_SelB, o_Op, o_WrAcc, o_Operand,
               o_RdRam, o_WrRam, o_Halt, o_Illegal, o_InstrCount
    );

    modport slave (
        output i_start, i_Instruction,
        input  o_PcAddr, o_SelA, o_SelB, o_Op, o_WrAcc, o_Operand,
               o_RdRam, o_WrRam, o_Halt, o_Illegal, o_InstrCount
    );
endinterface

// File: rtl/bip_pc.sv
// Program counter: synchronous reset, single-step increment, natural wrap
// at 2^NBITS_O.
module bip_pc #(
    parameter int NBITS_O = 11
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               inc_i,
    output logic [NBITS_O-1:0] pc_o
);
    logic [NBITS_O-1:0] pc_q;
    logic [NBITS_O-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (inc_i) begin
            pc_d = pc_q + NBITS_O'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/bip_control.sv
// BIP I control unit: fetches from synchronous program memory, sequences each
// instruction through IDLE/FETCH/DECODE/MEMRD/EXEC/HALT and drives the datapath.
module bip_control
    import bip_pkg::*;
#(
    parameter int NBITS_O = 11,
    parameter int NBITS_E = 5,
    parameter int NBITS_C = 16
) (
    input  logic i_clock,
    input  logic i_reset,
    bip_if.master bus
);
    localparam int NBITS_I = NBITS_E + NBITS_O;

    state_e             state_q, state_d;
    logic [NBITS_I-1:0] ir_q;
    logic [1:0]         sel_a_q, sel_a_d;
    logic               sel_b_q, sel_b_d;
    logic               op_q, op_d;
    logic               illegal_q;
    logic [NBITS_C-1:0] count_q;
    logic [4:0]         ir_opc;
    logic [4:0]         in_opc;
    logic               pc_inc;

    assign ir_opc = ir_q[NBITS_I-1 -: 5];
    assign in_opc = bus.i_Instruction[NBITS_I-1 -: 5];
    assign pc_inc = (state_q == ST_EXEC);

    bip_pc #(.NBITS_O(NBITS_O)) u_pc (
        .clk_i (i_clock),
        .rst_i (i_reset),
        .inc_i (pc_inc),
        .pc_o  (bus.o_PcAddr)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (bus.i_start) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                if (in_opc == OP_HLT)       state_d = ST_HALT;
                else if (needs_memrd(in_opc)) state_d = ST_MEMRD;
                else                        state_d = ST_EXEC;
            end
            ST_MEMRD:  state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath selects are decoded straight from the incoming word so they are
    // already stable in the first cycle after DECODE.
    always_comb begin
        sel_a_d = SELA_MEM;
        sel_b_d = 1'b0;
        op_d    = 1'b0;
        unique case (in_opc)
            OP_LDI:          sel_a_d = SELA_IMM;
            OP_ADD, OP_SUB:  sel_a_d = SELA_ALU;
            OP_ADDI, OP_SUBI: begin
                sel_a_d = SELA_ALU;
                sel_b_d = 1'b1;
            end
            default:         sel_a_d = SELA_MEM;
        endcase
        if (in_opc == OP_SUB || in_opc == OP_SUBI) begin
            op_d = 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            ir_q      <= '0;
            sel_a_q   <= SELA_MEM;
            sel_b_q   <= 1'b0;
            op_q      <= 1'b0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                ir_q    <= bus.i_Instruction;
                sel_a_q <= sel_a_d;
                sel_b_q <= sel_b_d;
                op_q    <= op_d;
                if (!is_legal(in_opc)) begin
                    illegal_q <= 1'b1;
                end
            end
            if (state_q == ST_EXEC) begin
                count_q <= count_q + NBITS_C'(1);
            end
        end
    end

    // Strobes are gated by reset so a reset edge never also performs an access.
    assign bus.o_WrAcc = !i_reset && (state_q == ST_EXEC) && writes_acc(ir_opc);
    assign bus.o_WrRam = !i_reset && (state_q == ST_EXEC) && (ir_opc == OP_STO);
    assign bus.o_RdRam = !i_reset && (state_q == ST_MEMRD);

    assign bus.o_SelA       = sel_a_q;
    assign bus.o_SelB       = sel_b_q;
    assign bus.o_Op         = op_q;
    assign bus.o_Operand    = ir_q[NBITS_O-1:0];
    assign bus.o_Halt       = (state_q == ST_HALT);
    assign bus.o_Illegal    = illegal_q;
    assign bus.o_InstrCount = count_q;
endmodule

// File: tb/tb_bip_control.sv
// Directed bench for bip_control with a synchronous program-memory model and
// hand-computed expectations for each instruction step.
module tb_bip_control;
    logic clk;
    logic rst;
    int unsigned n_cmp;
    int unsigned n_err;
    logic [15:0] prog [2048];

    bip_if #(.NBITS_O(11), .NBITS_E(5), .NBITS_C(16)) bus ();

    bip_control #(.NBITS_O(11), .NBITS_E(5), .NBITS_C(16)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.i_Instruction <= prog[bus.o_PcAddr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_start = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic pulse_start();
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
    endtask

    function automatic logic [31:0] strobes();
        return {29'd0, bus.o_WrAcc, bus.o_WrRam, bus.o_RdRam};
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        bus.i_start = 1'b0;
        bus.i_Instruction = '0;
        for (int i = 0; i < 2048; i++) prog[i] = 16'h0000;
        prog[0] = 16'h1805;
        prog[1] = 16'h2003;
        prog[2] = 16'h0807;
        prog[3] = 16'h0000;

        rst = 1'b1;
        step();
        step();
        check_eq("rst_pc",      32'(bus.o_PcAddr), 32'd0);
        check_eq("rst_strobes", strobes(), 32'd0);
        check_eq("rst_sel",     32'({bus.o_SelA, bus.o_SelB, bus.o_Op}), 32'd0);
        check_eq("rst_flags",   32'({bus.o_Halt, bus.o_Illegal}), 32'd0);
        check_eq("rst_count",   32'(bus.o_InstrCount), 32'd0);
        rst = 1'b0;
        step();
        check_eq("idle_pc", 32'(bus.o_PcAddr), 32'd0);

        // LDI 5
        pulse_start();
        check_eq("ldi_fetch_pc",  32'(bus.o_PcAddr), 32'd0);
        check_eq("ldi_fetch_str", strobes(), 32'd0);
        step();
        check_eq("ldi_decode_str", strobes(), 32'd0);
        step();
        check_eq("ldi_exec_str",  strobes(), 32'b100);
        check_eq("ldi_exec_sela", 32'(bus.o_SelA), 32'd1);
        check_eq("ldi_exec_opnd", 32'(bus.o_Operand), 32'd5);
        step();
        check_eq("ldi_pc",    32'(bus.o_PcAddr), 32'd1);
        check_eq("ldi_count", 32'(bus.o_InstrCount), 32'd1);

        // ADD 3
        step();
        step();
        check_eq("add_memrd_str",  strobes(), 32'b001);
        check_eq("add_memrd_opnd", 32'(bus.o_Operand), 32'd3);
        step();
        check_eq("add_exec_str", strobes(), 32'b100);
        check_eq("add_exec_sel", 32'({bus.o_SelA, bus.o_SelB, bus.o_Op}), 32'b1000);
        step();
        check_eq("add_pc_cnt", 32'({bus.o_PcAddr, bus.o_InstrCount}), {5'd0, 11'd2, 16'd2});

        // STO 7
        step();
        step();
        check_eq("sto_exec_str",  strobes(), 32'b010);
        check_eq("sto_exec_opnd", 32'(bus.o_Operand), 32'd7);
        step();
        check_eq("sto_pc_cnt", 32'({bus.o_PcAddr, bus.o_InstrCount}), {5'd0, 11'd3, 16'd3});

        // HLT
        step();
        check_eq("hlt_decode_halt", 32'(bus.o_Halt), 32'd0);
        step();
        check_eq("hlt_halt", 32'(bus.o_Halt), 32'd1);
        for (int i = 0; i < 20; i++) begin
            bus.i_start = i[0];
            step();
            check_eq("halt_hold",
                     32'({bus.o_Halt, bus.o_PcAddr, bus.o_InstrCount, bus.o_WrAcc, bus.o_WrRam, bus.o_RdRam}),
                     {1'b0, 1'b1, 11'd3, 16'd3, 3'b000});
        end
        bus.i_start = 1'b0;

        // Illegal opcode then SUBI 2
        prog[0] = 16'hF801;
        prog[1] = 16'h3802;
        prog[2] = 16'h0000;
        do_reset();
        check_eq("ill_after_rst", 32'(bus.o_Illegal), 32'd0);
        pulse_start();
        step();
        check_eq("ill_decode", 32'(bus.o_Illegal), 32'd0);
        step();
        check_eq("ill_exec_flag", 32'(bus.o_Illegal), 32'd1);
        check_eq("ill_exec_str",  strobes(), 32'd0);
        step();
        check_eq("ill_pc_cnt", 32'({bus.o_PcAddr, bus.o_InstrCount}), {5'd0, 11'd1, 16'd1});
        step();
        step();
        check_eq("subi_exec_str",  strobes(), 32'b100);
        check_eq("subi_exec_sel",  32'({bus.o_SelA, bus.o_SelB, bus.o_Op}), 32'b1011);
        check_eq("subi_exec_opnd", 32'(bus.o_Operand), 32'd2);
        check_eq("ill_sticky",     32'(bus.o_Illegal), 32'd1);
        step();
        check_eq("subi_pc_cnt", 32'({bus.o_PcAddr, bus.o_InstrCount}), {5'd0, 11'd2, 16'd2});

        // Reset during MEMRD of LD 3
        prog[0] = 16'h1003;
        do_reset();
        pulse_start();
        step();
        step();
        check_eq("ld_memrd_str", strobes(), 32'b001);
        rst = 1'b1;
        #1;
        check_eq("rst_memrd_suppress", strobes(), 32'd0);
        step();
        rst = 1'b0;
        check_eq("rst_memrd_pc",  32'(bus.o_PcAddr), 32'd0);
        check_eq("rst_memrd_str", strobes(), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("rst_back_idle", 32'({bus.o_PcAddr, bus.o_InstrCount, bus.o_WrAcc, bus.o_WrRam, bus.o_RdRam}),
                     32'd0);
        end

        // PC wrap 2047 -> 0 using a program of LDI 1
        for (int i = 0; i < 2048; i++) prog[i] = 16'h1801;
        do_reset();
        pulse_start();
        begin
            int unsigned budget;
            budget = 0;
            while (bus.o_PcAddr != 11'd2047 && budget < 8000) begin
                step();
                budget++;
            end
            check_eq("wrap_reach_2047", 32'(bus.o_PcAddr), 32'd2047);
        end
        check_eq("wrap_count_before", 32'(bus.o_InstrCount), 32'd2047);
        step();
        step();
        step();
        check_eq("wrap_pc",    32'(bus.o_PcAddr), 32'd0);
        check_eq("wrap_count", 32'(bus.o_InstrCount), 32'd2048);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
